// File: rtl/jar_sram_pkg.sv
// Shared types and constants for the nibble-serial burst SRAM.
// Opcodes are four bits wide; frame nibble counts come from the bus geometry.
package jar_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RLOAD,
    RDATA,
    ERR
  } state_e;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  function automatic int calc_anib(input int aw, input int nw);
    return aw / nw;
  endfunction

  function automatic int calc_dnib(input int dw, input int nw);
    return dw / nw;
  endfunction

endpackage

// File: rtl/jar_sram_array.sv
// DEPTH x DW storage: synchronous write, combinational read.
// Out-of-range addresses drop writes and read back as zero.
module jar_sram_array #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok = {1'b0, waddr} < DEPTH_W;
  assign rd_ok = {1'b0, raddr} < DEPTH_W;

  // No reset: contents deliberately survive rst_n.
  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rd_ok ? mem[raddr] : '0;

endmodule

// File: rtl/jar_sram_burst.sv
// Nibble-serial SRAM with framed opcode/address/data protocol and burst auto-increment.
//   state | meaning
//   IDLE  | waiting for the opcode nibble of a new frame
//   ADDR  | collecting address nibbles, low nibble first
//   WDATA | assembling write words; each full word is written and addr advances
//   RLOAD | one-cycle fetch of mem[addr] into the shift register
//   RDATA | streaming shift register out over dout valid/ready
//   ERR   | bad opcode; parked until sel drops
module jar_sram_burst
  import jar_sram_pkg::*;
#(
  parameter int NW    = 4,
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic [NW-1:0] din,
  input  logic          din_valid,
  output logic [NW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          err
);

  localparam int ANIB = calc_anib(AW, NW);
  localparam int DNIB = calc_dnib(DW, NW);
  localparam int CW   = 8;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          dout_valid_q, dout_valid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_shift;
  logic [DW-1:0] data_shift;

  jar_sram_array #(
    .DW   (DW),
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(data_shift),
    .raddr(addr_q),
    .rdata(mem_rdata)
  );

  // Incoming nibbles enter at the top so the first one ends up in the low bits.
  assign addr_shift = AW'({din, addr_q} >> NW);
  assign data_shift = DW'({din, shreg_q} >> NW);
  assign addr_inc   = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    mem_we  = 1'b0;
    if (!sel) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (din_valid) begin
            cnt_d = CW'(ANIB - 1);
            if (din == NW'(OP_WRITE)) begin
              is_wr_d = 1'b1;
              state_d = ADDR;
            end else if (din == NW'(OP_READ)) begin
              is_wr_d = 1'b0;
              state_d = ADDR;
            end else begin
              state_d = ERR;
            end
          end
        end
        ADDR: begin
          if (din_valid) begin
            addr_d = addr_shift;
            if (cnt_q == '0) begin
              cnt_d   = CW'(DNIB - 1);
              state_d = is_wr_q ? WDATA : RLOAD;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        WDATA: begin
          if (din_valid) begin
            shreg_d = data_shift;
            if (cnt_q == '0) begin
              mem_we = 1'b1;
              addr_d = addr_inc;
              cnt_d  = CW'(DNIB - 1);
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        RLOAD: begin
          shreg_d = mem_rdata;
          cnt_d   = CW'(DNIB - 1);
          state_d = RDATA;
        end
        RDATA: begin
          if (dout_ready) begin
            shreg_d = shreg_q >> NW;
            if (cnt_q == '0) begin
              addr_d  = addr_inc;
              state_d = RLOAD;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: state_d = IDLE;
      endcase
    end
    dout_valid_d = (state_d == RDATA);
    busy_d       = (state_d != IDLE);
    err_d        = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_wr_q      <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      shreg_q      <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      shreg_q      <= shreg_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign dout       = shreg_q[NW-1:0];
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_jar_sram_burst.sv
// Directed bench for jar_sram_burst: write/read bursts, wrap, abort, backpressure,
// bad opcode and asynchronous reset mid-read.
module tb_jar_sram_burst;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic [3:0] din;
  logic       din_valid;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       err;

  int checks;
  int errors;

  jar_sram_burst #(
    .NW(4), .DW(8), .AW(4), .DEPTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    sel       = 1'b1;
    din       = n;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic end_frame();
    sel        = 1'b0;
    dout_ready = 1'b0;
    tick();
  endtask

  // Reads n nibbles starting at addr a; expected nibble i is exp[4*i +: 4].
  task automatic do_read(input string name, input logic [3:0] a, input int n,
                         input logic [15:0] exp);
    int got;
    got = 0;
    send(4'h2);
    send(a);
    dout_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (dout_valid) begin
        checks++;
        if (dout !== exp[4*got +: 4]) begin
          errors++;
          $display("FAIL %s nibble %0d: got %h expected %h", name, got, dout, exp[4*got +: 4]);
        end
        got++;
      end
      if (got == n) break;
      tick();
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s timeout: got %0d nibbles expected %0d", name, got, n);
    end
    end_frame();
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b dout_valid=%b err=%b expected 0 0 0", busy, dout_valid, err);
    end
  endtask

  task automatic test_write_burst();
    logic [3:0] nibs [6];
    nibs = '{4'h1, 4'h5, 4'hA, 4'h3, 4'hC, 4'h4};
    for (int i = 0; i < 6; i++) begin
      send(nibs[i]);
      checks++;
      if (busy !== 1'b1 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL write_burst step %0d: busy=%b dout_valid=%b expected 1 0", i, busy, dout_valid);
      end
    end
    end_frame();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL write_burst busy after sel low: got %b expected 0", busy);
    end
  endtask

  task automatic test_read_burst();
    logic       exp_v [6];
    logic [3:0] exp_d [6];
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_d = '{4'h0, 4'hA, 4'h3, 4'h0, 4'hC, 4'h4};
    send(4'h2);
    dout_ready = 1'b1;
    send(4'h5);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout_valid !== exp_v[i] || (exp_v[i] && dout !== exp_d[i])) begin
        errors++;
        $display("FAIL read_burst cycle %0d: valid=%b dout=%h expected valid=%b dout=%h",
                 i, dout_valid, dout, exp_v[i], exp_d[i]);
      end
      if (i < 5) tick();
    end
    end_frame();
  endtask

  task automatic test_wrap();
    send(4'h1); send(4'hF); send(4'h1); send(4'h1); send(4'h2); send(4'h2);
    end_frame();
    do_read("wrap", 4'hF, 4, 16'h2211);
  endtask

  task automatic test_abort_backpressure();
    send(4'h1); send(4'h7); send(4'hE); send(4'h5);
    end_frame();
    send(4'h1); send(4'h7); send(4'h9);
    end_frame();
    do_read("abort_mem7", 4'h7, 2, 16'h005E);

    send(4'h2);
    dout_ready = 1'b0;
    send(4'h5);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 4'hA) begin
        errors++;
        $display("FAIL backpressure hold %0d: valid=%b dout=%h expected 1 a", i, dout_valid, dout);
      end
      tick();
    end
    dout_ready = 1'b1;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 4'hA) begin
      errors++;
      $display("FAIL backpressure release: valid=%b dout=%h expected 1 a", dout_valid, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 4'h3) begin
      errors++;
      $display("FAIL backpressure second: valid=%b dout=%h expected 1 3", dout_valid, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure bubble: valid=%b expected 0", dout_valid);
    end
    end_frame();
  endtask

  task automatic test_bad_opcode();
    logic [3:0] nibs [4];
    nibs = '{4'h7, 4'h0, 4'h5, 4'h5};
    for (int i = 0; i < 4; i++) begin
      send(nibs[i]);
      checks++;
      if (err !== 1'b1 || busy !== 1'b1 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad_opcode step %0d: err=%b busy=%b valid=%b expected 1 1 0",
                 i, err, busy, dout_valid);
      end
    end
    end_frame();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode after sel low: err=%b busy=%b expected 0 0", err, busy);
    end
    do_read("after_bad_op", 4'h5, 4, 16'h4C3A);
  endtask

  task automatic test_reset_mid_read();
    send(4'h2);
    dout_ready = 1'b0;
    send(4'h6);
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 4'hC) begin
      errors++;
      $display("FAIL reset_mid_read pre: valid=%b dout=%h expected 1 c", dout_valid, dout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read async: valid=%b busy=%b err=%b expected 0 0 0",
               dout_valid, busy, err);
    end
    sel = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_read("after_reset", 4'h6, 2, 16'h004C);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    sel        = 1'b0;
    din        = 4'h0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #3;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_abort_backpressure();
    test_bad_opcode();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
